// File: rtl/register_rename_fl.sv
// Rename stage: speculative and committed RATs over a circular free list, with
// single-cycle flush recovery from the committed state.
package register_rename_fl_pkg;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned NUM_PHYS_REGS = 128;
    localparam int unsigned AREG_W        = $clog2(NUM_ARCH_REGS);
    localparam int unsigned PTR_W         = $clog2(NUM_PHYS_REGS);
    localparam int unsigned OPC_W         = 7;
    localparam int unsigned IMM_W         = 32;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [AREG_W-1:0] rd;
        logic [AREG_W-1:0] rs1;
        logic [AREG_W-1:0] rs2;
        logic [IMM_W-1:0]  imm;
    } instruction_decoded_t;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [PTR_W-1:0] rd;
        logic [PTR_W-1:0] rs1;
        logic [PTR_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } instruction_renamed_t;
endpackage

module register_rename_fl #(
    parameter int unsigned ARCH_REGS = register_rename_fl_pkg::NUM_ARCH_REGS,
    parameter int unsigned PHYS_REGS = register_rename_fl_pkg::NUM_PHYS_REGS,
    localparam int unsigned PTR_W    = $clog2(PHYS_REGS),
    localparam int unsigned AREG_W   = $clog2(ARCH_REGS),
    localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS,
    localparam int unsigned CNT_W    = $clog2(FL_DEPTH + 1)
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  register_rename_fl_pkg::instruction_decoded_t instruction_i,
    input  logic                                         valid_i,
    output logic                                         ready_i,
    output register_rename_fl_pkg::instruction_renamed_t instruction_o,
    output logic [PTR_W-1:0]                             prd_old_o,
    output logic                                         valid_o,
    input  logic                                         ready_o,
    input  logic                                         commit_valid_i,
    input  logic [AREG_W-1:0]                            commit_rd_i,
    input  logic [PTR_W-1:0]                             commit_prd_i,
    input  logic [PTR_W-1:0]                             commit_prd_old_i,
    input  logic                                         flush_i,
    output logic [CNT_W-1:0]                             free_count_o
);
    localparam int unsigned IDX_W = $clog2(FL_DEPTH);

    // Free-list pointer: index modulo FL_DEPTH plus a lap bit to tell full from empty.
    typedef struct packed {
        logic             wrap;
        logic [IDX_W-1:0] idx;
    } fl_ptr_t;

    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
        fl_ptr_t r;
        if (32'(p.idx) == FL_DEPTH - 1) begin
            r.idx  = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = p.idx + IDX_W'(1);
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] occupancy(input fl_ptr_t t, input fl_ptr_t h);
        if (t.wrap == h.wrap) return CNT_W'(32'(t.idx) - 32'(h.idx));
        return CNT_W'(FL_DEPTH + 32'(t.idx) - 32'(h.idx));
    endfunction

    fl_ptr_t head, tail, commit_head;
    fl_ptr_t head_nxt, tail_nxt, commit_head_nxt;
    logic    fire, has_rd, alloc, commit;

    logic [PTR_W-1:0] spec_rat   [ARCH_REGS];
    logic [PTR_W-1:0] commit_rat [ARCH_REGS];
    logic [PTR_W-1:0] free_list  [FL_DEPTH];

    register_rename_fl_pkg::instruction_renamed_t renamed;
    logic [PTR_W-1:0]                             prd_old_nxt;

    // Upstream accepts only when the output slot drains and a free register is guaranteed.
    assign ready_i = (~valid_o | ready_o) & ~flush_i & (free_count_o != '0);
    assign fire    = valid_i & ready_i;
    assign has_rd  = instruction_i.rd != '0;
    assign alloc   = fire & has_rd;
    assign commit  = commit_valid_i & (commit_rd_i != '0);

    always_comb begin
        head_nxt        = alloc  ? ptr_inc(head)        : head;
        tail_nxt        = commit ? ptr_inc(tail)        : tail;
        commit_head_nxt = commit ? ptr_inc(commit_head) : commit_head;
        if (flush_i) head_nxt = commit_head_nxt;
    end

    // Sources read the RAT before this instruction's own destination update.
    always_comb begin
        renamed        = '0;
        renamed.opcode = instruction_i.opcode;
        renamed.imm    = instruction_i.imm;
        renamed.rs1    = spec_rat[instruction_i.rs1];
        renamed.rs2    = spec_rat[instruction_i.rs2];
        prd_old_nxt    = '0;
        if (has_rd) begin
            renamed.rd  = free_list[head.idx];
            prd_old_nxt = spec_rat[instruction_i.rd];
        end
    end

    for (genvar g = 0; g < ARCH_REGS; g++) begin : g_rat
        logic [PTR_W-1:0] spec_q, commit_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                spec_q   <= PTR_W'(g);
                commit_q <= PTR_W'(g);
            end else begin
                if (commit && commit_rd_i == AREG_W'(g)) commit_q <= commit_prd_i;
                // Flush restores from the committed view, folding in a same-cycle commit.
                if (flush_i)
                    spec_q <= (commit && commit_rd_i == AREG_W'(g)) ? commit_prd_i : commit_q;
                else if (alloc && instruction_i.rd == AREG_W'(g))
                    spec_q <= free_list[head.idx];
            end
        end

        assign spec_rat[g]   = spec_q;
        assign commit_rat[g] = commit_q;
    end

    for (genvar g = 0; g < FL_DEPTH; g++) begin : g_fl
        logic [PTR_W-1:0] entry_q;

        always_ff @(posedge clk) begin
            if (reset) entry_q <= PTR_W'(ARCH_REGS + g);
            else if (commit && tail.idx == IDX_W'(g)) entry_q <= commit_prd_old_i;
        end

        assign free_list[g] = entry_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            commit_head   <= '0;
            tail          <= '{wrap: 1'b1, idx: '0};
            free_count_o  <= CNT_W'(FL_DEPTH);
            valid_o       <= 1'b0;
            instruction_o <= '0;
            prd_old_o     <= '0;
        end else begin
            head         <= head_nxt;
            tail         <= tail_nxt;
            commit_head  <= commit_head_nxt;
            free_count_o <= occupancy(tail_nxt, head_nxt);
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (fire) begin
                valid_o       <= 1'b1;
                instruction_o <= renamed;
                prd_old_o     <= prd_old_nxt;
            end else if (ready_o) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_register_rename_fl.sv
// Randomized bench for register_rename_fl against a queue-based rename model
// (free list as a FIFO, in-flight renames as an ordered list).
module tb_register_rename_fl;
    import register_rename_fl_pkg::*;

    localparam int unsigned FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned CNT_W    = $clog2(FL_DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    instruction_decoded_t instruction_i;
    logic                 valid_i, ready_i;
    instruction_renamed_t instruction_o;
    logic [PTR_W-1:0]     prd_old_o;
    logic                 valid_o, ready_o;
    logic                 commit_valid_i;
    logic [AREG_W-1:0]    commit_rd_i;
    logic [PTR_W-1:0]     commit_prd_i, commit_prd_old_i;
    logic                 flush_i;
    logic [CNT_W-1:0]     free_count_o;

    register_rename_fl dut (
        .clk(clk), .reset(reset),
        .instruction_i(instruction_i), .valid_i(valid_i), .ready_i(ready_i),
        .instruction_o(instruction_o), .prd_old_o(prd_old_o),
        .valid_o(valid_o), .ready_o(ready_o),
        .commit_valid_i(commit_valid_i), .commit_rd_i(commit_rd_i),
        .commit_prd_i(commit_prd_i), .commit_prd_old_i(commit_prd_old_i),
        .flush_i(flush_i), .free_count_o(free_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        int prd;
        int old;
    } rob_t;

    int                   m_spec   [NUM_ARCH_REGS];
    int                   m_commit [NUM_ARCH_REGS];
    int                   fl_q [$];
    rob_t                 rob [$];
    logic                 m_valid;
    instruction_renamed_t m_instr;
    int                   m_old;
    int                   checks = 0;
    int                   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic instruction_decoded_t mk_ins(input int rd, input int rs1, input int rs2);
        instruction_decoded_t r;
        r.opcode = 7'($urandom);
        r.rd     = 5'(rd);
        r.rs1    = 5'(rs1);
        r.rs2    = 5'(rs2);
        r.imm    = $urandom;
        return r;
    endfunction

    function automatic instruction_decoded_t rand_ins(input bit nz_rd);
        return mk_ins(nz_rd ? int'($urandom_range(1, 31)) : int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            m_spec[i]   = i;
            m_commit[i] = i;
        end
        fl_q.delete();
        for (int i = NUM_ARCH_REGS; i < NUM_PHYS_REGS; i++) fl_q.push_back(i);
        rob.delete();
        m_valid = 1'b0;
        m_instr = '0;
        m_old   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        valid_i        = 1'b1;
        instruction_i  = rand_ins(1);
        ready_o        = 1'b1;
        commit_valid_i = 1'b1;
        commit_rd_i    = 5'd3;
        commit_prd_i   = 7'd77;
        commit_prd_old_i = 7'd3;
        flush_i        = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check("rst_valid_o", 64'(valid_o), 64'(0));
        check("rst_free_count", 64'(free_count_o), 64'(FL_DEPTH));
        check("rst_prd_old", 64'(prd_old_o), 64'(0));
        check("rst_instr_o", 64'(instruction_o), 64'(0));
        reset          = 1'b0;
        valid_i        = 1'b0;
        commit_valid_i = 1'b0;
        flush_i        = 1'b0;
    endtask

    // One clock: drive at negedge, check ready, advance the model at posedge, check outputs.
    task automatic step(input logic v, input instruction_decoded_t ins, input logic ro,
                        input logic do_commit, input logic fl);
        logic cv;
        logic [AREG_W-1:0] crd;
        logic [PTR_W-1:0] cprd, cold;
        logic exp_ready;
        int p;
        @(negedge clk);
        cv = do_commit;
        if (do_commit && rob.size() > 0) begin
            crd  = 5'(rob[0].rd);
            cprd = 7'(rob[0].prd);
            cold = 7'(rob[0].old);
        end else begin
            crd  = do_commit ? 5'd0 : 5'($urandom);
            cprd = 7'($urandom);
            cold = 7'($urandom);
        end
        valid_i          = v;
        instruction_i    = ins;
        ready_o          = ro;
        commit_valid_i   = cv;
        commit_rd_i      = crd;
        commit_prd_i     = cprd;
        commit_prd_old_i = cold;
        flush_i          = fl;
        exp_ready = (!m_valid || ro) && !fl && (fl_q.size() != 0);
        #1 check("ready_i", 64'(ready_i), 64'(exp_ready));
        @(posedge clk);
        if (v && exp_ready) begin
            m_instr.opcode = ins.opcode;
            m_instr.imm    = ins.imm;
            m_instr.rs1    = 7'(m_spec[ins.rs1]);
            m_instr.rs2    = 7'(m_spec[ins.rs2]);
            if (ins.rd != 0) begin
                p = fl_q.pop_front();
                m_old = m_spec[ins.rd];
                m_spec[ins.rd] = p;
                rob.push_back('{rd: int'(ins.rd), prd: p, old: m_old});
                m_instr.rd = 7'(p);
            end else begin
                m_instr.rd = '0;
                m_old = 0;
            end
            m_valid = 1'b1;
        end else if (fl || ro) begin
            m_valid = 1'b0;
        end
        if (cv && crd != 0) begin
            m_commit[crd] = int'(cprd);
            fl_q.push_back(int'(cold));
            rob.delete(0);
        end
        if (fl) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) m_spec[i] = m_commit[i];
            for (int i = rob.size() - 1; i >= 0; i--) fl_q.push_front(rob[i].prd);
            rob.delete();
        end
        #1;
        check("valid_o", 64'(valid_o), 64'(m_valid));
        check("instruction_o", 64'(instruction_o), 64'(m_instr));
        check("prd_old_o", 64'(prd_old_o), 64'(m_old));
        check("free_count_o", 64'(free_count_o), 64'(fl_q.size()));
    endtask

    initial begin
        reset = 1'b1;
        valid_i = 1'b0;
        instruction_i = '0;
        ready_o = 1'b1;
        commit_valid_i = 1'b0;
        commit_rd_i = '0;
        commit_prd_i = '0;
        commit_prd_old_i = '0;
        flush_i = 1'b0;
        do_reset();

        // add x5,x1,x2 then x5 <- x5,x3 back-to-back
        step(1'b1, mk_ins(5, 1, 2), 1'b1, 1'b0, 1'b0);
        check("first_rd", 64'(instruction_o.rd), 64'(32));
        check("first_rs1", 64'(instruction_o.rs1), 64'(1));
        check("first_rs2", 64'(instruction_o.rs2), 64'(2));
        check("first_prd_old", 64'(prd_old_o), 64'(5));
        step(1'b1, mk_ins(5, 5, 3), 1'b1, 1'b0, 1'b0);
        check("second_rs1", 64'(instruction_o.rs1), 64'(32));
        check("second_rd", 64'(instruction_o.rd), 64'(33));
        check("second_prd_old", 64'(prd_old_o), 64'(32));

        // Drain the free list completely, then free one register.
        for (int i = 0; i < int'(FL_DEPTH) - 2; i++) step(1'b1, rand_ins(1), 1'b1, 1'b0, 1'b0);
        check("empty_count", 64'(free_count_o), 64'(0));
        step(1'b1, rand_ins(1), 1'b1, 1'b1, 1'b0);
        check("refill_ready", 64'(ready_i), 64'(1));
        step(1'b1, mk_ins(9, 1, 1), 1'b1, 1'b0, 1'b0);
        check("reuse_freed_rd", 64'(instruction_o.rd), 64'(5));

        // Downstream stall while commits continue.
        for (int i = 0; i < 5; i++) step(1'b1, rand_ins(1), 1'b0, 1'b1, 1'b0);
        step(1'b1, rand_ins(1), 1'b1, 1'b0, 1'b0);

        // Flush on the same cycle as the 4th commit.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, rand_ins(1), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, rand_ins(1), 1'b1, 1'b1, 1'b0);
        step(1'b0, rand_ins(1), 1'b1, 1'b1, 1'b1);
        check("flush_count", 64'(free_count_o), 64'(FL_DEPTH));
        check("flush_valid", 64'(valid_o), 64'(0));
        for (int i = 0; i < 8; i++) step(1'b1, rand_ins(0), 1'b1, 1'b0, 1'b0);

        // Destination x0 allocates nothing.
        step(1'b1, mk_ins(0, 4, 6), 1'b1, 1'b0, 1'b0);
        check("x0_rd", 64'(instruction_o.rd), 64'(0));
        check("x0_prd_old", 64'(prd_old_o), 64'(0));

        // Steady alloc/commit pairs to wrap all pointers several times.
        for (int i = 0; i < 300; i++) step(1'b1, rand_ins(1), 1'b1, 1'b1, 1'b0);

        // Random mix of renames, stalls, commits and flushes.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, rand_ins($urandom_range(0, 4) != 0),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 49) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
